// File: rtl/req_buffer_bank.sv
// req_buffer_bank: a bank of independent circular request FIFOs with one
// drain-to-empty output port that moves round-robin between buffers.
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous, active-low reset
//   wr_en         per-buffer push strobe; data_in is pushed into every set bit
//   data_in       request payload
//   free_size     empty entries per buffer, buffer i at [i*CNT_W +: CNT_W]
//   out_valid     head of the selected buffer is valid
//   out_ready     downstream accepts out_data this cycle
//   out_data      head entry of the selected buffer
//   out_buf_idx   index of the selected buffer
//   overflow_err  sticky: a push was attempted into a full buffer
module req_buffer_bank #(
    parameter int unsigned NUM_OF_BUFFERS = 4,
    parameter int unsigned BUFFER_SIZE    = 4,
    parameter int unsigned DATA_WIDTH     = 31
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [NUM_OF_BUFFERS-1:0]                                    wr_en,
    input  logic [DATA_WIDTH-1:0]                                        data_in,
    output logic [NUM_OF_BUFFERS*($clog2(BUFFER_SIZE)+1)-1:0]            free_size,
    output logic                                                         out_valid,
    input  logic                                                         out_ready,
    output logic [DATA_WIDTH-1:0]                                        out_data,
    output logic [((NUM_OF_BUFFERS > 1) ? $clog2(NUM_OF_BUFFERS) : 1)-1:0] out_buf_idx,
    output logic                                                         overflow_err
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SEL_W = (NUM_OF_BUFFERS > 1) ? $clog2(NUM_OF_BUFFERS) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

    logic [NUM_OF_BUFFERS-1:0]                 nonempty;
    logic [NUM_OF_BUFFERS-1:0]                 full_hit;
    logic [NUM_OF_BUFFERS-1:0][DATA_WIDTH-1:0] head;
    logic [SEL_W-1:0]                          sel;
    logic [SEL_W-1:0]                          sel_nxt;
    logic [SEL_W-1:0]                          cand;
    logic                                      found;
    logic                                      pop;

    // Output port view of the selected buffer; valid never looks at out_ready.
    assign out_valid   = nonempty[sel];
    assign out_data    = head[sel];
    assign out_buf_idx = sel;
    assign pop         = out_valid & out_ready;

    // Per-buffer FIFO: storage, pointers and occupancy kept local to each slot.
    for (genvar g = 0; g < NUM_OF_BUFFERS; g++) begin : g_buf
        logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      count;
        logic                  push;
        logic                  pop_here;

        // A push into a full buffer is dropped even if it is popped this cycle.
        assign push     = wr_en[g] && (count != FULL);
        assign pop_here = pop && (sel == SEL_W'(g));
        assign full_hit[g] = wr_en[g] && (count == FULL);
        assign nonempty[g] = (count != '0);
        assign head[g]     = mem[rd_ptr];
        assign free_size[g*CNT_W +: CNT_W] = FULL - count;

        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_here) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop_here})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // Storage is intentionally not reset.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= data_in;
            end
        end
    end

    // Next selection: hold while the current buffer has data, otherwise take
    // the first non-empty buffer after it in cyclic order.
    always_comb begin
        sel_nxt = sel;
        found   = 1'b0;
        cand    = sel;
        if (!nonempty[sel]) begin
            for (int unsigned k = 1; k <= NUM_OF_BUFFERS; k++) begin
                cand = SEL_W'((32'(sel) + k) % NUM_OF_BUFFERS);
                if (!found && nonempty[cand]) begin
                    sel_nxt = cand;
                    found   = 1'b1;
                end
            end
        end
    end

    // Selection register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel          <= '0;
            overflow_err <= 1'b0;
        end else begin
            sel <= sel_nxt;
            if (|full_hit) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/req_buffer_bank.md
REQ_BUFFER_BANK -- requirements
Module: req_buffer_bank

Interface
REQ-001 Parameter NUM_OF_BUFFERS, default 4, SHALL set the number of independent request FIFOs.
REQ-002 Parameter BUFFER_SIZE, default 4, SHALL set the depth of each FIFO and SHALL be a power of two ≥ 2.
REQ-003 Parameter DATA_WIDTH, default 31, SHALL set the width of a stored request (type bit already stripped upstream).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 wr_en  input  NUM_OF_BUFFERS  per-buffer push strobe from the selector stage.
REQ-007 data_in  input  DATA_WIDTH  request pushed into every buffer whose wr_en bit is set.
REQ-008 free_size  output  NUM_OF_BUFFERS x (clog2(BUFFER_SIZE)+1)  empty entries per buffer, packed in the same layout the selector consumes.
REQ-009 out_valid  output  1  head of the currently selected buffer is valid.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DATA_WIDTH  head entry of the selected buffer.
REQ-012 out_buf_idx  output  clog2(NUM_OF_BUFFERS)  index of the selected buffer.
REQ-013 overflow_err  output  1  sticky flag: a push was attempted into a full buffer.

Function
REQ-014 Each buffer SHALL be a circular FIFO with write pointer, read pointer (clog2(BUFFER_SIZE) bits, natural wrap) and occupancy count (clog2(BUFFER_SIZE)+1 bits).
REQ-015 free_size[i] SHALL equal BUFFER_SIZE minus count[i], derived combinationally from registered count.
REQ-016 A push into buffer i SHALL occur when wr_en[i]=1 and count[i]<BUFFER_SIZE; data SHALL be visible at the head no earlier than the next cycle.
REQ-017 A push with wr_en[i]=1 and count[i]=BUFFER_SIZE SHALL be dropped (no pointer or count change) and SHALL set overflow_err, even if buffer i is popped in the same cycle.
REQ-018 Multiple wr_en bits set in one cycle SHALL push data_in into each selected buffer independently.
REQ-019 A pop of buffer sel SHALL occur when out_valid=1 and out_ready=1, advancing its read pointer by one.
REQ-020 Push and pop on the same buffer in one cycle (not full) SHALL leave count unchanged and advance both pointers.
REQ-021 Register sel (clog2(NUM_OF_BUFFERS) bits) SHALL drive out_buf_idx; out_valid SHALL equal (count[sel]!=0); out_data SHALL equal the entry at read pointer of buffer sel.
REQ-022 Drain policy: while count[sel]!=0, sel SHALL hold, so a buffer is drained to empty before switching (preserves row-hit batching).
REQ-023 When count[sel]=0, sel SHALL load, on the next edge, the first index j in cyclic order sel+1, sel+2, ..., sel (wrapping modulo NUM_OF_BUFFERS) with count[j]!=0; if none, sel SHALL hold.
REQ-024 Switching SHALL cost exactly one bubble cycle (out_valid=0) between draining one buffer and presenting the next.
REQ-025 out_data SHALL be don't-care while out_valid=0; out_valid SHALL not depend combinationally on out_ready.
REQ-026 Memory contents SHALL not be reset; only pointers, counts, sel and overflow_err.

Reset
REQ-027 With reset=0 at a clock edge: all pointers and counts SHALL be 0, sel SHALL be 0, overflow_err SHALL be 0.
REQ-028 After reset: free_size SHALL read BUFFER_SIZE for every buffer, out_valid=0, out_buf_idx=0.
REQ-029 Reset SHALL override any simultaneous push or pop; in-flight entries SHALL be discarded.
REQ-030 overflow_err SHALL clear only by reset.

Verification
REQ-031 Push A,B,C into buffer 0 on consecutive cycles, out_ready=1 -> out_data A,B,C on consecutive cycles from cycle after first push, free_size[0] returns to 4.
REQ-032 Push 4 entries into buffer 2, then 5th push -> free_size[2]=0, 5th dropped, overflow_err=1 and stays 1; 4 entries pop in order.
REQ-033 Buffer 0 holds 2, buffer 1 holds 1, buffer 3 holds 1, out_ready=1 -> pops 0,0, bubble, 1, bubble, 3; out_buf_idx sequence 0,0,0,1,1,3.
REQ-034 Buffer 1 full, simultaneous push to 1 and pop from 1 -> push dropped, overflow_err=1, count[1]=3.
REQ-035 Buffer 0 holds 1, push to 0 and pop in same cycle, out_ready held -> count stays 1, new entry presented next cycle, no bubble.
REQ-036 Reset asserted while buffers 0 and 2 hold data -> next cycle all free_size=4, out_valid=0, sel=0.
